cond_incr_exec: RTL and testbench

Sequential execution unit for conditional-increment operations on the LCISC execution environment. It owns the environment's u32 register file and flag register. It accepts one decoded conditional-increment operation per handshake and applies it over a fixed multi-cycle sequence: flag gate, compare, increment, flag update. It sits directly downstream of the operation-argument constructor and upstream of the environment result/trace consumer.

---
 rtl/cond_incr_exec_if.sv | 35 +++
 rtl/cond_incr_exec.sv | 193 +++++++++++++++++++
 tb/tb_cond_incr_exec.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_incr_exec_if.sv
// Operation/completion bus for the conditional-increment execution unit.
// op_*: a transfer happens on a rising edge where op_valid && op_ready; the
// master holds op_* stable while op_valid is high. done_* is a one-cycle
// pulse with no backpressure.
interface cond_incr_exec_if #(
  parameter int AW = 4,
  parameter int FW = 4
);
  logic          op_valid;
  logic          op_ready;
  logic [AW-1:0] op_target;
  logic [2:0]    op_cmp;
  logic          op_cmp_is_addr;
  logic [31:0]   op_cmp_val;
  logic          op_inc_is_addr;
  logic [31:0]   op_inc_val;
  logic [FW-1:0] op_set_flag;
  logic [FW-1:0] op_cond_flag;
  logic          done_valid;
  logic          done_executed;
  logic          done_taken;
  logic [31:0]   done_value;

  modport master (
    output op_valid, op_target, op_cmp, op_cmp_is_addr, op_cmp_val,
           op_inc_is_addr, op_inc_val, op_set_flag, op_cond_flag,
    input  op_ready, done_valid, done_executed, done_taken, done_value
  );

  modport slave (
    input  op_valid, op_target, op_cmp, op_cmp_is_addr, op_cmp_val,
           op_inc_is_addr, op_inc_val, op_set_flag, op_cond_flag,
    output op_ready, done_valid, done_executed, done_taken, done_value
  );
endinterface

// File: rtl/cond_incr_exec.sv
// Conditional-increment execution unit: owns the u32 register file and flag
// register, runs each accepted op through gate, compare, increment, flag update.
module cond_incr_exec #(
  parameter  int NUM_REGS  = 16,
  parameter  int NUM_FLAGS = 8,
  localparam int AW        = $clog2(NUM_REGS),
  localparam int FW        = $clog2(NUM_FLAGS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  cond_incr_exec_if.slave      bus,
  input  logic                 load_en,
  input  logic [AW-1:0]        load_addr,
  input  logic [31:0]          load_data,
  output logic [NUM_FLAGS-1:0] flags,
  input  logic [AW-1:0]        dbg_addr,
  output logic [31:0]          dbg_data,
  output logic [1:0]           dbg_state
);

  localparam logic [FW-1:0] FLAG_NONE = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_EVAL  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   regs [NUM_REGS];

  logic [AW-1:0] tgt_q;
  logic [2:0]    cmp_q;
  logic          cmp_addr_q;
  logic [31:0]   cmp_val_q;
  logic          inc_addr_q;
  logic [31:0]   inc_val_q;
  logic [FW-1:0] set_q;
  logic [FW-1:0] cond_q;

  logic          done_valid_q;
  logic          done_exec_q;
  logic          done_taken_q;
  logic [31:0]   done_value_q;

  logic          accept, load_we, gate_fail, eval_en, write_en;
  logic          op_ready_c;
  logic [31:0]   a_val, c_val, i_val;
  logic          cmp_res, gate_pass;

  // Out-of-range register indices read as zero.
  function automatic logic [31:0] reg_rd(input logic [AW-1:0] idx);
    return (32'(idx) < NUM_REGS) ? regs[idx] : 32'd0;
  endfunction

  // Selects in NUM_FLAGS..NONE (including NONE) read as zero.
  function automatic logic flag_rd(input logic [FW-1:0] sel);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (32'(sel) == i) r = flags[i];
    end
    return r;
  endfunction

  always_comb begin
    a_val     = reg_rd(tgt_q);
    c_val     = cmp_addr_q ? reg_rd(cmp_val_q[AW-1:0]) : cmp_val_q;
    i_val     = inc_addr_q ? reg_rd(inc_val_q[AW-1:0]) : inc_val_q;
    gate_pass = (cond_q == FLAG_NONE) || flag_rd(cond_q);
    case (cmp_q)
      3'd0:    cmp_res = (a_val == c_val);
      3'd1:    cmp_res = (a_val != c_val);
      3'd2:    cmp_res = (a_val <  c_val);
      3'd3:    cmp_res = (a_val <= c_val);
      3'd4:    cmp_res = (a_val >  c_val);
      3'd5:    cmp_res = (a_val >= c_val);
      default: cmp_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    op_ready_c = 1'b0;
    accept     = 1'b0;
    load_we    = 1'b0;
    gate_fail  = 1'b0;
    eval_en    = 1'b0;
    write_en   = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready_c = 1'b1;
        if (bus.op_valid) begin
          accept    = 1'b1;
          state_nxt = S_GATE;
        end else if (load_en) begin
          load_we = 1'b1;
        end
      end
      S_GATE: begin
        if (gate_pass) begin
          state_nxt = S_EVAL;
        end else begin
          gate_fail = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_EVAL: begin
        eval_en   = 1'b1;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        write_en  = done_taken_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The completion record is registered one cycle ahead of its pulse, so the
  // value computed in EVAL doubles as the write data in WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q        <= '0;
      cmp_q        <= '0;
      cmp_addr_q   <= 1'b0;
      cmp_val_q    <= '0;
      inc_addr_q   <= 1'b0;
      inc_val_q    <= '0;
      set_q        <= FLAG_NONE;
      cond_q       <= FLAG_NONE;
      done_valid_q <= 1'b0;
      done_exec_q  <= 1'b0;
      done_taken_q <= 1'b0;
      done_value_q <= '0;
    end else begin
      done_valid_q <= 1'b0;
      if (accept) begin
        tgt_q      <= bus.op_target;
        cmp_q      <= bus.op_cmp;
        cmp_addr_q <= bus.op_cmp_is_addr;
        cmp_val_q  <= bus.op_cmp_val;
        inc_addr_q <= bus.op_inc_is_addr;
        inc_val_q  <= bus.op_inc_val;
        set_q      <= bus.op_set_flag;
        cond_q     <= bus.op_cond_flag;
      end
      if (gate_fail) begin
        done_valid_q <= 1'b1;
        done_exec_q  <= 1'b0;
        done_taken_q <= 1'b0;
        done_value_q <= a_val;
      end
      if (eval_en) begin
        done_valid_q <= 1'b1;
        done_exec_q  <= 1'b1;
        done_taken_q <= cmp_res;
        done_value_q <= cmp_res ? (a_val + i_val) : a_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      flags <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_we && (32'(load_addr) == i)) regs[i] <= load_data;
        if (write_en && (32'(tgt_q) == i))    regs[i] <= done_value_q;
      end
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (eval_en && (32'(set_q) == i)) flags[i] <= cmp_res;
      end
    end
  end

  assign bus.op_ready      = op_ready_c;
  assign bus.done_valid    = done_valid_q;
  assign bus.done_executed = done_exec_q;
  assign bus.done_taken    = done_taken_q;
  assign bus.done_value    = done_value_q;
  assign dbg_data          = reg_rd(dbg_addr);
  assign dbg_state         = state;

endmodule

// File: tb/tb_cond_incr_exec.sv
// Directed bench for cond_incr_exec: an architectural model predicts each
// completion (cycle and fields); a per-cycle compare process checks done_*.
module tb_cond_incr_exec;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam logic [3:0] NONE = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cond_incr_exec_if #(.AW(AW), .FW(FW)) bus();
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [7:0]    flags;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data;
  logic [1:0]    dbg_state;

  cond_incr_exec dut (
    .clk(clk), .rst(rst), .bus(bus),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural model.
  logic [31:0] mregs [16];
  logic [7:0]  mflags;
  // {done cycle[65:34], executed[33], taken[32], value[31:0]}
  logic [65:0] exp_q[$];
  logic [65:0] e;
  logic        last_exec, last_taken;
  logic [31:0] last_value;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] idx);
    return (idx < 16) ? mregs[idx[3:0]] : 32'd0;
  endfunction

  function automatic logic m_flag(input logic [3:0] s);
    return (s < 8) ? mflags[s[2:0]] : 1'b0;
  endfunction

  function automatic logic m_cmp(input logic [2:0] code, input logic [31:0] a, input logic [31:0] c);
    case (code)
      3'd0: return a == c;
      3'd1: return a != c;
      3'd2: return a <  c;
      3'd3: return a <= c;
      3'd4: return a >  c;
      3'd5: return a >= c;
      default: return 1'b0;
    endcase
  endfunction

  // Every non-reset cycle: done must pulse exactly when the model says so.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() != 0 && exp_q[0][65:34] == cyc) begin
        e = exp_q.pop_front();
        chk("done_valid", 32'(bus.done_valid), 32'd1);
        chk("done_executed", 32'(bus.done_executed), 32'(e[33]));
        chk("done_taken", 32'(bus.done_taken), 32'(e[32]));
        chk("done_value", bus.done_value, e[31:0]);
        last_exec  = bus.done_executed;
        last_taken = bus.done_taken;
        last_value = bus.done_value;
      end else begin
        chk("done_quiet", 32'(bus.done_valid), 32'd0);
      end
    end
  end

  task automatic do_load(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = a; load_data = d;
    mregs[a] = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] tgt, input logic [2:0] code,
                       input logic ca, input logic [31:0] cv,
                       input logic ia, input logic [31:0] iv,
                       input logic [3:0] sf, input logic [3:0] cf,
                       input bit hold = 1'b0, input bit with_load = 1'b0,
                       input bit abort = 1'b0);
    logic [31:0] n, a, c, inc;
    logic t;
    @(posedge clk); #1;
    chk("op_ready_idle", 32'(bus.op_ready), 32'd1);
    bus.op_valid = 1'b1; bus.op_target = tgt; bus.op_cmp = code;
    bus.op_cmp_is_addr = ca; bus.op_cmp_val = cv;
    bus.op_inc_is_addr = ia; bus.op_inc_val = iv;
    bus.op_set_flag = sf; bus.op_cond_flag = cf;
    if (with_load) begin
      load_en = 1'b1; load_addr = 4'd9; load_data = 32'h55;
    end
    n = cyc;
    if (!(cf == NONE || m_flag(cf))) begin
      exp_q.push_back({n + 32'd2, 1'b0, 1'b0, mregs[tgt]});
    end else begin
      a   = mregs[tgt];
      c   = ca ? m_rd({28'd0, cv[3:0]}) : cv;
      inc = ia ? m_rd({28'd0, iv[3:0]}) : iv;
      t   = m_cmp(code, a, c);
      if (sf < 8) mflags[sf[2:0]] = t;
      if (t) mregs[tgt] = a + inc;
      exp_q.push_back({n + 32'd3, 1'b1, t, mregs[tgt]});
    end
    @(posedge clk); #1;
    load_en = 1'b0;
    if (hold) begin
      // Still presented but must be ignored; scramble fields to prove latching.
      bus.op_cmp_val = $urandom; bus.op_inc_val = $urandom;
      bus.op_target  = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
    if (abort) begin
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mflags = '0;
      #1;
      chk("abort_op_ready", 32'(bus.op_ready), 32'd1);
      chk("abort_done_valid", 32'(bus.done_valid), 32'd0);
      return;
    end
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_pulse required=pulse");
      exp_q.delete();
    end
  endtask

  task automatic check_reg(input logic [3:0] a);
    dbg_addr = a; #1;
    chk($sformatf("reg%0d", a), dbg_data, mregs[a]);
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++) check_reg(4'(i));
    chk("flags_model", 32'(flags), 32'(mflags));
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_target = '0; bus.op_cmp = '0;
    bus.op_cmp_is_addr = 1'b0; bus.op_cmp_val = '0;
    bus.op_inc_is_addr = 1'b0; bus.op_inc_val = '0;
    bus.op_set_flag = NONE; bus.op_cond_flag = NONE;
    load_en = 1'b0; load_addr = '0; load_data = '0; dbg_addr = '0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflags = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
    chk("rst_done_executed", 32'(bus.done_executed), 32'd0);
    chk("rst_done_taken", 32'(bus.done_taken), 32'd0);
    chk("rst_done_value", bus.done_value, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_state_idle", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    check_all();

    // Basic LT hit
    do_load(4'd3, 32'd5);
    do_op(4'd3, 3'd2, 1'b0, 32'd10, 1'b0, 32'd1, NONE, NONE);
    chk("lit_lt_exec", 32'(last_exec), 32'd1);
    chk("lit_lt_taken", 32'(last_taken), 32'd1);
    chk("lit_lt_value", last_value, 32'd6);
    dbg_addr = 4'd3; #1;
    chk("lit_reg3_6", dbg_data, 32'd6);

    // LT miss writes flag 0, then GE hit writes flag 1
    do_load(4'd3, 32'd10);
    do_op(4'd3, 3'd2, 1'b0, 32'd10, 1'b0, 32'd1, 4'd2, NONE);
    chk("lit_ltmiss_taken", 32'(last_taken), 32'd0);
    chk("lit_ltmiss_value", last_value, 32'd10);
    chk("lit_flag2_0", 32'(flags[2]), 32'd0);
    do_op(4'd3, 3'd5, 1'b0, 32'd10, 1'b0, 32'd1, 4'd2, NONE);
    chk("lit_ge_value", last_value, 32'd11);
    chk("lit_flag2_1", 32'(flags[2]), 32'd1);

    // Gated off, then enable flag 1 and retry with op_valid held
    do_op(4'd3, 3'd2, 1'b0, 32'd100, 1'b0, 32'd1, NONE, 4'd1);
    chk("lit_gated_exec", 32'(last_exec), 32'd0);
    chk("lit_gated_value", last_value, 32'd11);
    do_op(4'd7, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd1, NONE);
    do_op(4'd3, 3'd2, 1'b0, 32'd100, 1'b0, 32'd1, NONE, 4'd1, 1'b1);
    chk("lit_retry_exec", 32'(last_exec), 32'd1);
    chk("lit_retry_value", last_value, 32'd12);
    chk("lit_flags_06", 32'(flags), 32'h06);

    // Wraparound
    do_load(4'd0, 32'hFFFF_FFFF);
    do_op(4'd0, 3'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'd2, NONE, NONE);
    chk("lit_wrap_value", last_value, 32'h0000_0001);

    // Register operands, self-compare
    do_load(4'd4, 32'd7);
    do_load(4'd5, 32'd7);
    do_load(4'd6, 32'd100);
    do_op(4'd4, 3'd0, 1'b1, 32'd5, 1'b1, 32'd6, NONE, NONE);
    chk("lit_addr_value", last_value, 32'd107);
    do_op(4'd4, 3'd4, 1'b1, 32'd4, 1'b0, 32'd1, NONE, NONE);
    chk("lit_gt_self_taken", 32'(last_taken), 32'd0);
    chk("lit_gt_self_value", last_value, 32'd107);

    // Codes 6/7, NE with self as increment source, out-of-range flag selects
    do_op(4'd4, 3'd6, 1'b0, 32'd0, 1'b0, 32'd1, NONE, NONE);
    do_op(4'd4, 3'd7, 1'b0, 32'd0, 1'b0, 32'd1, NONE, NONE);
    chk("lit_code7_taken", 32'(last_taken), 32'd0);
    do_op(4'd5, 3'd1, 1'b1, 32'd4, 1'b1, 32'd5, NONE, NONE);
    chk("lit_ne_self_value", last_value, 32'd14);
    do_op(4'd5, 3'd3, 1'b0, 32'd14, 1'b0, 32'd1, 4'd12, NONE);
    chk("lit_le_value", last_value, 32'd15);
    chk("lit_flags_oor_write", 32'(flags), 32'h06);
    do_op(4'd5, 3'd0, 1'b0, 32'd15, 1'b0, 32'd1, NONE, 4'd9);
    chk("lit_oor_gate_exec", 32'(last_exec), 32'd0);
    do_op(4'd6, 3'd5, 1'b0, 32'd0, 1'b0, 32'd0, 4'd7, NONE);
    chk("lit_flags_86", 32'(flags), 32'h86);

    // Load and op in the same cycle: load dropped
    do_op(4'd8, 3'd0, 1'b0, 32'd0, 1'b0, 32'd3, NONE, NONE, 1'b0, 1'b1);
    chk("lit_reg8_value", last_value, 32'd3);
    dbg_addr = 4'd9; #1;
    chk("lit_load_dropped", dbg_data, 32'd0);
    check_all();

    // Reset during EVAL
    do_op(4'd2, 3'd0, 1'b0, 32'd0, 1'b0, 32'd5, 4'd0, NONE, 1'b0, 1'b0, 1'b1);
    chk("lit_abort_flags", 32'(flags), 32'd0);
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();

    // Alive after reset
    do_load(4'd1, 32'd1);
    do_op(4'd1, 3'd2, 1'b0, 32'd2, 1'b0, 32'd1, NONE, NONE);
    chk("lit_post_rst_value", last_value, 32'd2);
    check_all();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
